// File: rtl/execute_pkg.sv
// rtl/execute_pkg.sv - shared widths, ALU opcodes and forwarding selects for the execute stage
package execute_pkg;
    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
endpackage

// File: rtl/execute_stage_if.sv
// rtl/execute_stage_if.sv - decode-to-execute inputs, fetch redirect and EX/MEM outputs
interface execute_stage_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
);
    logic                  regwriteE;
    logic                  memwriteE;
    logic                  branchE;
    logic                  alusrcE;
    logic                  resultsrcE;
    logic [2:0]            alucontrolE;
    logic [DATA_W-1:0]     r1E;
    logic [DATA_W-1:0]     r2E;
    logic [REG_ADDR_W-1:0] RdE;
    logic [DATA_W-1:0]     imm_addrE;
    logic [DATA_W-1:0]     pcE;
    logic [DATA_W-1:0]     pc4E;
    logic [1:0]            forwardAE;
    logic [1:0]            forwardBE;
    logic [DATA_W-1:0]     ResultW;

    logic                  pcsrcE;
    logic [DATA_W-1:0]     pctargetE;
    logic                  regwriteM;
    logic                  memwriteM;
    logic                  resultsrcM;
    logic [REG_ADDR_W-1:0] RdM;
    logic [DATA_W-1:0]     aluresultM;
    logic [DATA_W-1:0]     writedataM;
    logic [DATA_W-1:0]     pc4M;

    modport master (
        output regwriteE, memwriteE, branchE, alusrcE, resultsrcE, alucontrolE,
               r1E, r2E, RdE, imm_addrE, pcE, pc4E, forwardAE, forwardBE, ResultW,
        input  pcsrcE, pctargetE, regwriteM, memwriteM, resultsrcM, RdM,
               aluresultM, writedataM, pc4M
    );

    modport slave (
        input  regwriteE, memwriteE, branchE, alusrcE, resultsrcE, alucontrolE,
               r1E, r2E, RdE, imm_addrE, pcE, pc4E, forwardAE, forwardBE, ResultW,
        output pcsrcE, pctargetE, regwriteM, memwriteM, resultsrcM, RdM,
               aluresultM, writedataM, pc4M
    );
endinterface

// File: rtl/exec_alu.sv
// rtl/exec_alu.sv - combinational RV32I ALU with zero flag
module exec_alu
    import execute_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [2:0]        alucontrol,
    output logic [DATA_W-1:0] result,
    output logic              zero
);
    always_comb begin
        result = '0;
        case (alucontrol)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_SLT: result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);
endmodule

// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - EX stage and EX/MEM register; operand forwarding under EXECUTE_FWD_EN
module execute_stage
    import execute_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input logic            clk,
    input logic            rst,
    execute_stage_if.slave ex
);
    logic [DATA_W-1:0]     op_a;
    logic [DATA_W-1:0]     op_b_pre;
    logic [DATA_W-1:0]     op_b;
    logic [DATA_W-1:0]     alu_result;
    logic                  alu_zero;
    logic                  pcsrc;

    logic                  squash_q, squash_d;
    logic                  regwrite_q, memwrite_q, resultsrc_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic [DATA_W-1:0]     aluresult_q, writedata_q, pc4_q;

`ifdef EXECUTE_FWD_EN
    function automatic logic [DATA_W-1:0] fwd_sel(
        input logic [1:0]        sel,
        input logic [DATA_W-1:0] reg_val,
        input logic [DATA_W-1:0] wb_val,
        input logic [DATA_W-1:0] mem_val
    );
        case (sel)
            FWD_WB:  return wb_val;
            FWD_MEM: return mem_val;
            default: return reg_val;
        endcase
    endfunction

    assign op_a     = fwd_sel(ex.forwardAE, ex.r1E, ex.ResultW, aluresult_q);
    assign op_b_pre = fwd_sel(ex.forwardBE, ex.r2E, ex.ResultW, aluresult_q);
`else
    logic unused_fwd;
    assign unused_fwd = ^{ex.forwardAE, ex.forwardBE, ex.ResultW};
    assign op_a       = ex.r1E;
    assign op_b_pre   = ex.r2E;
`endif

    assign op_b = ex.alusrcE ? ex.imm_addrE : op_b_pre;

    exec_alu #(.DATA_W(DATA_W)) u_alu (
        .a          (op_a),
        .b          (op_b),
        .alucontrol (ex.alucontrolE),
        .result     (alu_result),
        .zero       (alu_zero)
    );

    // Instruction following a taken branch is wrong-path: it may neither redirect nor commit.
    assign pcsrc        = rst & ex.branchE & alu_zero & ~squash_q;
    assign squash_d     = pcsrc;
    assign ex.pcsrcE    = pcsrc;
    assign ex.pctargetE = ex.pcE + ex.imm_addrE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            squash_q    <= 1'b0;
            regwrite_q  <= 1'b0;
            memwrite_q  <= 1'b0;
            resultsrc_q <= 1'b0;
            rd_q        <= '0;
            aluresult_q <= '0;
            writedata_q <= '0;
            pc4_q       <= '0;
        end else begin
            squash_q    <= squash_d;
            regwrite_q  <= ex.regwriteE & ~squash_q;
            memwrite_q  <= ex.memwriteE & ~squash_q;
            resultsrc_q <= ex.resultsrcE;
            rd_q        <= ex.RdE;
            aluresult_q <= alu_result;
            writedata_q <= op_b_pre;
            pc4_q       <= ex.pc4E;
        end
    end

    assign ex.regwriteM  = regwrite_q;
    assign ex.memwriteM  = memwrite_q;
    assign ex.resultsrcM = resultsrc_q;
    assign ex.RdM        = rd_q;
    assign ex.aluresultM = aluresult_q;
    assign ex.writedataM = writedata_q;
    assign ex.pc4M       = pc4_q;
endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - randomized self-checking bench for execute_stage against a behavioural model
module tb_execute_stage;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    execute_stage_if #(.DATA_W(32), .REG_ADDR_W(5)) bus ();

    execute_stage #(.DATA_W(32), .REG_ADDR_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .ex  (bus.slave)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model state: what the M stage should hold, and whether the previous instruction redirected.
    logic [31:0]  m_alu;
    logic         last_taken;
    logic [103:0] exp_m, act_m;
    logic [32:0]  exp_comb, act_comb;

    function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = a;
        sb = b;
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd5: return (sa < sb) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] src_ref(input logic [1:0] sel, input logic [31:0] rv,
                                            input logic [31:0] wb, input logic [31:0] mem);
`ifdef EXECUTE_FWD_EN
        if (sel == 2'd1) return wb;
        if (sel == 2'd2) return mem;
        return rv;
`else
        return (sel == 2'd3) ? rv : rv ^ (wb & 32'd0) ^ (mem & 32'd0);
`endif
    endfunction

    function automatic logic [103:0] m_now();
        return {bus.regwriteM, bus.memwriteM, bus.resultsrcM, bus.RdM,
                bus.aluresultM, bus.writedataM, bus.pc4M};
    endfunction

    task automatic model_reset();
        m_alu      = 32'd0;
        last_taken = 1'b0;
        exp_m      = '0;
    endtask

    // One instruction: drive at negedge, sample redirect, then sample the EX/MEM register after the edge.
    task automatic cycle(input logic rw, input logic mw, input logic br, input logic as, input logic rs,
                         input logic [2:0] ac, input logic [31:0] r1, input logic [31:0] r2,
                         input logic [31:0] imm, input logic [31:0] pc, input logic [4:0] rd,
                         input logic [1:0] fa, input logic [1:0] fb, input logic [31:0] wb);
        logic [31:0] a, bpre, b, res;
        logic taken;
        @(negedge clk);
        bus.regwriteE = rw;  bus.memwriteE = mw;  bus.branchE = br;
        bus.alusrcE = as;    bus.resultsrcE = rs; bus.alucontrolE = ac;
        bus.r1E = r1;        bus.r2E = r2;        bus.RdE = rd;
        bus.imm_addrE = imm; bus.pcE = pc;        bus.pc4E = pc + 32'd4;
        bus.forwardAE = fa;  bus.forwardBE = fb;  bus.ResultW = wb;
        a     = src_ref(fa, r1, wb, m_alu);
        bpre  = src_ref(fb, r2, wb, m_alu);
        b     = as ? imm : bpre;
        res   = alu_ref(ac, a, b);
        taken = br && (res == 32'd0) && !last_taken;
        exp_comb = {taken, pc + imm};
        #1 act_comb = {bus.pcsrcE, bus.pctargetE};
        @(posedge clk);
        #1;
        exp_m = {rw && !last_taken, mw && !last_taken, rs, rd, res, bpre, pc + 32'd4};
        act_m = m_now();
        last_taken = taken;
        m_alu = res;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.regwriteE = 1; bus.memwriteE = 1; bus.branchE = 1; bus.alusrcE = 0;
        bus.resultsrcE = 1; bus.alucontrolE = 3'd1; bus.r1E = 7; bus.r2E = 7;
        bus.RdE = 5'd3; bus.imm_addrE = 32'h20; bus.pcE = 32'h100; bus.pc4E = 32'h104;
        bus.forwardAE = 0; bus.forwardBE = 0; bus.ResultW = 32'h55;
        #1;
        n_vec++;
        if (bus.pcsrcE !== 1'b0) begin
            n_err++; $display("FAIL reset_pcsrc: got %b expected 0", bus.pcsrcE);
        end
        repeat (2) @(posedge clk);
        #1 act_m = m_now();
        n_vec++;
        if (act_m !== 104'd0) begin
            n_err++; $display("FAIL reset_m: got %h expected 0", act_m);
        end
        rst = 1'b1;
        model_reset();
        cycle(1, 1, 0, 0, 1, 3'd0, 32'd3, 32'd4, 32'd0, 32'h40, 5'd9, 2'd0, 2'd0, 32'd0);
        n_vec++;
        if (act_m !== exp_m || act_m[95:64] !== 32'd7) begin
            n_err++; $display("FAIL reset_release_load: got %h expected %h", act_m, exp_m);
        end
    endtask

    task automatic test_alu();
        cycle(1, 0, 0, 0, 0, 3'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h200, 5'd1, 2'd0, 2'd0, 32'd0);
        n_vec++;
        if (act_m[95:64] !== 32'd0 || act_m !== exp_m) begin
            n_err++; $display("FAIL alu_add_wrap: got %h expected %h", act_m, exp_m);
        end
        cycle(1, 0, 0, 0, 0, 3'd5, 32'hFFFF_FFFE, 32'd1, 32'd0, 32'h204, 5'd2, 2'd0, 2'd0, 32'd0);
        n_vec++;
        if (act_m[95:64] !== 32'd1 || act_m !== exp_m) begin
            n_err++; $display("FAIL alu_slt_signed: got %h expected %h", act_m, exp_m);
        end
        for (int i = 0; i < 40; i++) begin
            cycle(1'($urandom), 1'($urandom), 0, 1'($urandom), 1'($urandom), 3'($urandom),
                  $urandom, $urandom, $urandom, $urandom, 5'($urandom), 2'd0, 2'd0, $urandom);
            n_vec++;
            if (act_m !== exp_m) begin
                n_err++; $display("FAIL alu_random: got %h expected %h", act_m, exp_m);
            end
        end
    endtask

    task automatic test_immediate();
        cycle(1, 0, 0, 1, 0, 3'd0, 32'd5, 32'hAA, 32'h10, 32'h300, 5'd4, 2'd0, 2'd0, 32'd0);
        n_vec++;
        if (act_m[95:64] !== 32'h15 || act_m[63:32] !== 32'hAA || act_m !== exp_m) begin
            n_err++; $display("FAIL immediate: got %h expected %h", act_m, exp_m);
        end
    endtask

    task automatic test_branch();
        cycle(0, 0, 1, 0, 0, 3'd1, 32'd7, 32'd7, 32'h20, 32'h100, 5'd0, 2'd0, 2'd0, 32'd0);
        n_vec++;
        if (act_comb !== {1'b1, 32'h120} || act_comb !== exp_comb) begin
            n_err++; $display("FAIL branch_taken: got %h expected %h", act_comb, exp_comb);
        end
        cycle(1, 1, 1, 0, 0, 3'd1, 32'd5, 32'd5, 32'h40, 32'h104, 5'd6, 2'd0, 2'd0, 32'd0);
        n_vec++;
        if (act_comb[32] !== 1'b0 || act_comb !== exp_comb) begin
            n_err++; $display("FAIL branch_second_redirect: got %h expected %h", act_comb, exp_comb);
        end
        n_vec++;
        if (act_m[103:102] !== 2'b00 || act_m !== exp_m) begin
            n_err++; $display("FAIL branch_squash_writes: got %h expected %h", act_m, exp_m);
        end
        cycle(1, 1, 0, 0, 0, 3'd0, 32'd1, 32'd2, 32'd0, 32'h120, 5'd7, 2'd0, 2'd0, 32'd0);
        n_vec++;
        if (act_m[103:102] !== 2'b11 || act_m !== exp_m) begin
            n_err++; $display("FAIL branch_squash_clears: got %h expected %h", act_m, exp_m);
        end
    endtask

    task automatic test_not_taken();
        cycle(0, 0, 1, 0, 0, 3'd1, 32'd3, 32'd4, 32'h80, 32'h400, 5'd0, 2'd0, 2'd0, 32'd0);
        n_vec++;
        if (act_comb[32] !== 1'b0 || act_comb !== exp_comb) begin
            n_err++; $display("FAIL not_taken_pcsrc: got %h expected %h", act_comb, exp_comb);
        end
        cycle(1, 1, 0, 0, 0, 3'd2, 32'hF0, 32'h3C, 32'd0, 32'h404, 5'd8, 2'd0, 2'd0, 32'd0);
        n_vec++;
        if (act_m[103:102] !== 2'b11 || act_m !== exp_m) begin
            n_err++; $display("FAIL not_taken_no_squash: got %h expected %h", act_m, exp_m);
        end
    endtask

    task automatic test_forwarding();
        logic [31:0] want_alu, want_wd;
`ifdef EXECUTE_FWD_EN
        want_alu = 32'h42;   want_wd = 32'd2;
`else
        want_alu = 32'h3000; want_wd = 32'h2000;
`endif
        cycle(1, 0, 0, 0, 0, 3'd0, 32'd1, 32'd1, 32'd0, 32'h500, 5'd10, 2'd0, 2'd0, 32'd0);
        cycle(1, 1, 0, 0, 0, 3'd0, 32'h1000, 32'h2000, 32'd0, 32'h504, 5'd11, 2'd1, 2'd2, 32'h40);
        n_vec++;
        if (act_m[95:64] !== want_alu || act_m[63:32] !== want_wd || act_m !== exp_m) begin
            n_err++; $display("FAIL forwarding: got %h expected %h", act_m, exp_m);
        end
    endtask

    task automatic test_mid_reset();
        cycle(0, 0, 1, 0, 0, 3'd1, 32'd9, 32'd9, 32'h10, 32'h600, 5'd0, 2'd0, 2'd0, 32'd0);
        #2 rst = 1'b0;
        #1 act_m = m_now();
        n_vec++;
        if (act_m !== 104'd0 || bus.pcsrcE !== 1'b0) begin
            n_err++; $display("FAIL mid_reset_clear: got %h/%b expected 0/0", act_m, bus.pcsrcE);
        end
        rst = 1'b1;
        model_reset();
        cycle(1, 1, 1, 0, 0, 3'd1, 32'd6, 32'd6, 32'h8, 32'h700, 5'd12, 2'd0, 2'd0, 32'd0);
        n_vec++;
        if (act_comb[32] !== 1'b1 || act_m[103:102] !== 2'b11 || act_m !== exp_m) begin
            n_err++; $display("FAIL mid_reset_first_not_squashed: got %h/%h expected %h/%h",
                              act_comb, act_m, exp_comb, exp_m);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r1;
        for (int i = 0; i < 150; i++) begin
            r1 = $urandom;
            cycle(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 1) == 1) ? 3'd1 : 3'($urandom), r1,
                  ($urandom_range(0, 1) == 1) ? r1 : $urandom, $urandom, $urandom,
                  5'($urandom), 2'($urandom), 2'($urandom), $urandom);
            n_vec++;
            if (act_comb !== exp_comb) begin
                n_err++; $display("FAIL random_redirect: got %h expected %h", act_comb, exp_comb);
            end
            n_vec++;
            if (act_m !== exp_m) begin
                n_err++; $display("FAIL random_m: got %h expected %h", act_m, exp_m);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_alu();
        test_immediate();
        test_branch();
        test_not_taken();
        test_forwarding();
        test_mid_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
